// File: rtl/c17_resp_checker.sv
// c17_resp_checker: response end of the ISCAS-85 c17 test interface.
// Accepts one applied vector per pat_valid cycle while a run is active,
// compares the observed {N22,N23} against a NAND-level golden model of c17,
// checks that vectors arrive in order 0..NPAT-1, counts mismatches and
// reports pass/fail once NPAT vectors have been accepted.
// Optional feature macro: C17_CHK_MISR_EN adds a MISR that compacts the
// observed responses into `signature`; without it `signature` is tied to 0.
//
// Handshake: a vector is consumed on every rising clock edge where the block
// is in RUN and pat_valid=1 (there is no ready; the checker is always able to
// accept). pat_valid outside RUN is ignored, and start is honoured only in
// IDLE or DONE.

module c17_resp_checker #(
    parameter int                NPAT      = 32,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pat_valid,
    input  logic [4:0]        pat,
    input  logic              resp_n22,
    input  logic              resp_n23,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_cnt,
    output logic [4:0]        first_err_idx,
    output logic              seq_err,
    output logic [MISR_W-1:0] signature,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NPAT - 1);
    localparam logic [5:0] ERR_MAX  = 6'd63;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_clear;
    logic       w_accept;

    logic [4:0] r_idx;
    logic [5:0] r_err_cnt;
    logic [4:0] r_first_err_idx;
    logic       r_seq_err;

    // Golden c17 netlist evaluated on the applied vector (never on idx).
    logic w_n1, w_n2, w_n3, w_n6, w_n7;
    logic w_n10, w_n11, w_n16, w_n19;
    logic w_exp22, w_exp23;
    logic w_mismatch;

    assign {w_n1, w_n2, w_n3, w_n6, w_n7} = pat;
    assign w_n10      = ~(w_n1 & w_n3);
    assign w_n11      = ~(w_n3 & w_n6);
    assign w_n16      = ~(w_n2 & w_n11);
    assign w_n19      = ~(w_n11 & w_n7);
    assign w_exp22    = ~(w_n10 & w_n16);
    assign w_exp23    = ~(w_n16 & w_n19);
    assign w_mismatch = ({resp_n22, resp_n23} != {w_exp22, w_exp23});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, run-start clear strobe and vector-accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A vector presented together with start is dropped.
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (pat_valid) begin
                    w_accept = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-run bookkeeping: vector index, error counter, first error, order check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx           <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_seq_err       <= 1'b0;
        end else if (w_clear) begin
            r_idx           <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_seq_err       <= 1'b0;
        end else if (w_accept) begin
            r_idx <= r_idx + 5'd1;
            if (w_mismatch) begin
                // err_cnt never wraps, so zero reliably means "no error yet".
                if (r_err_cnt == '0) begin
                    r_first_err_idx <= r_idx;
                end
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + 6'd1;
                end
            end
            if (pat != r_idx) begin
                r_seq_err <= 1'b1;
            end
        end
    end

`ifdef C17_CHK_MISR_EN
    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_sig_nxt;

    // MISR step: shift left, fold in the polynomial on carry-out, XOR the response pair into bits [1:0].
    always_comb begin
        w_sig_nxt = {r_sig[MISR_W-2:0], 1'b0}
                  ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                  ^ {{(MISR_W-2){1'b0}}, resp_n22, resp_n23};
    end

    // Signature register, reseeded at reset and at every run start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= MISR_SEED;
        end else if (w_clear) begin
            r_sig <= MISR_SEED;
        end else if (w_accept) begin
            r_sig <= w_sig_nxt;
        end
    end

    assign signature = r_sig;
`else
    logic w_unused_misr_params;

    assign w_unused_misr_params = ^{MISR_POLY, MISR_SEED};
    assign signature            = '0;
`endif

    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign pass          = done && (r_err_cnt == '0) && !r_seq_err;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;
    assign seq_err       = r_seq_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_c17_resp_checker.sv
// tb_c17_resp_checker: randomized scoreboard bench for c17_resp_checker.
// Each run is planned as a list of (vector, response) pairs; the expected
// end-of-run result is computed from that list with a sum-of-products c17
// model and pushed into exp_q before the run is driven. A monitor pops and
// compares whenever done rises. Build with +define+C17_CHK_MISR_EN to also
// check the signature.

module tb_c17_resp_checker;

    localparam int NPAT  = 32;
    localparam int EXP_W = 6 + 5 + 1 + 1 + 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start     = 1'b0;
    logic        pat_valid = 1'b0;
    logic [4:0]  pat       = '0;
    logic        resp_n22  = 1'b0;
    logic        resp_n23  = 1'b0;
    logic        busy, done, pass, seq_err;
    logic [5:0]  err_cnt;
    logic [4:0]  first_err_idx;
    logic [15:0] signature;
    logic [1:0]  dbg_state;

    c17_resp_checker dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pat_valid     (pat_valid),
        .pat           (pat),
        .resp_n22      (resp_n22),
        .resp_n23      (resp_n23),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .seq_err       (seq_err),
        .signature     (signature),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EXP_W-1:0] exp_q[$];     // {err[28:23], first[22:18], seq[17], pass[16], sig[15:0]}
    int               exp_cyc_q[$]; // cycle at which done must first be seen
    logic [4:0]       plan_pat[$];
    logic [1:0]       plan_resp[$];
    logic             prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Two-level form of c17: N22 = N1.N3 + N2.!(N3.N6); N23 = N2.!(N3.N6) + N7.!(N3.N6).
    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, g;
        {n1, n2, n3, n6, n7} = v;
        g = n2 & !(n3 & n6);
        return {(n1 & n3) | g, g | (n7 & !(n3 & n6))};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
        logic [15:0] t;
        t = s << 1;
        if (s[15]) t = t ^ 16'h1021;
        t[1:0] = t[1:0] ^ r;
        return t;
    endfunction

    function automatic logic [EXP_W-1:0] model_run();
        int          errs  = 0;
        int          first = 0;
        bit          seq   = 0;
        logic [15:0] sig   = 16'h0000;
        foreach (plan_pat[k]) begin
            if (plan_resp[k] != c17_ref(plan_pat[k])) begin
                if (errs == 0) first = k;
                if (errs < 63) errs++;
            end
            if (int'(plan_pat[k]) != k) seq = 1;
            sig = misr_step(sig, plan_resp[k]);
        end
`ifndef C17_CHK_MISR_EN
        sig = 16'h0000;
`endif
        return {6'(errs), 5'(first), seq, (errs == 0) && !seq, sig};
    endfunction

    // ---------------- plan builders ----------------
    task automatic plan_golden();
        plan_pat.delete();
        plan_resp.delete();
        for (int i = 0; i < NPAT; i++) begin
            plan_pat.push_back(5'(i));
            plan_resp.push_back(c17_ref(5'(i)));
        end
    endtask

    task automatic plan_random();
        logic [4:0] p;
        logic [1:0] r;
        plan_pat.delete();
        plan_resp.delete();
        for (int i = 0; i < NPAT; i++) begin
            p = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'(i);
            r = c17_ref(p);
            if ($urandom_range(0, 3) == 0) r = r ^ 2'($urandom_range(1, 3));
            plan_pat.push_back(p);
            plan_resp.push_back(r);
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_busy"},      32'(busy),          32'd0);
        check({pfx, "_done"},      32'(done),          32'd0);
        check({pfx, "_pass"},      32'(pass),          32'd0);
        check({pfx, "_err_cnt"},   32'(err_cnt),       32'd0);
        check({pfx, "_first_err"}, 32'(first_err_idx), 32'd0);
        check({pfx, "_seq_err"},   32'(seq_err),       32'd0);
        check({pfx, "_signature"}, 32'(signature),     32'd0);
    endtask

    // ---------------- driver ----------------
    // abort_after >= 0 asserts rst before that vector and expects no result.
    task automatic exec_plan(input bit gaps, input bit rand_start, input bit start_with_valid,
                             input int abort_after);
        int t;
        if (abort_after < 0) exp_q.push_back(model_run());
        @(posedge clk); #1;
        start = 1'b1;
        if (start_with_valid) begin
            pat_valid = 1'b1;
            pat       = 5'($urandom_range(0, 31));
            {resp_n22, resp_n23} = ~c17_ref(pat);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        pat_valid = 1'b0;
        foreach (plan_pat[k]) begin
            if (abort_after == k) begin
                #2 rst = 1'b1;
                #1 check_idle_outputs("abort");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            while (gaps && $urandom_range(0, 2) == 0) begin
                pat_valid = 1'b0;
                start     = rand_start && ($urandom_range(0, 1) == 1);
                @(posedge clk); #1;
            end
            pat_valid = 1'b1;
            pat       = plan_pat[k];
            {resp_n22, resp_n23} = plan_resp[k];
            start     = rand_start && ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if (k == plan_pat.size() - 1) exp_cyc_q.push_back(cyc);
        end
        pat_valid = 1'b0;
        start     = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("run_done_seen", 32'(done), 32'd1);
        if (done !== 1'b1) begin
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no completed run (t=%0t)", $time);
            end else begin
                check("err_cnt",       32'(err_cnt),       32'(exp_q[0][28:23]));
                check("first_err_idx", 32'(first_err_idx), 32'(exp_q[0][22:18]));
                check("seq_err",       32'(seq_err),       32'(exp_q[0][17]));
                check("pass",          32'(pass),          32'(exp_q[0][16]));
                check("signature",     32'(signature),     32'(exp_q[0][15:0]));
                check("busy_at_done",  32'(busy),          32'd0);
                if (exp_cyc_q.size() != 0) begin
                    check("done_latency", 32'(cyc), 32'(exp_cyc_q[0]));
                    void'(exp_cyc_q.pop_front());
                end
                void'(exp_q.pop_front());
            end
        end
        prev_done <= done;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b0;

        // Golden run.
        plan_golden();
        exec_plan(0, 0, 0, -1);

        // Single inverted N22 on vector 5.
        plan_golden();
        plan_resp[5][1] = ~plan_resp[5][1];
        exec_plan(0, 0, 0, -1);

        // N22 stuck at 0; the start cycle also carries a bogus vector that must be dropped.
        plan_golden();
        foreach (plan_resp[k]) plan_resp[k][1] = 1'b0;
        exec_plan(0, 0, 1, -1);

        // Vector 7 skipped, one extra correct vector appended.
        plan_pat.delete();
        plan_resp.delete();
        for (int i = 0; i < NPAT; i++) begin
            if (i != 7) begin
                plan_pat.push_back(5'(i));
                plan_resp.push_back(c17_ref(5'(i)));
            end
        end
        plan_pat.push_back(5'($urandom_range(0, 31)));
        plan_resp.push_back(c17_ref(plan_pat[NPAT-1]));
        exec_plan(0, 0, 0, -1);

        // Reset after 10 vectors, then a clean golden run.
        plan_golden();
        exec_plan(0, 0, 0, 10);
        plan_golden();
        exec_plan(0, 0, 0, -1);

        // Golden run with valid gaps and ignored start pulses.
        plan_golden();
        exec_plan(1, 1, 0, -1);

        // Randomized runs with injected response errors and out-of-order vectors.
        for (int r = 0; r < 6; r++) begin
            plan_random();
            exec_plan(1, r[0], r[1], -1);
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
